// File: rtl/spi2apb3_host_master.sv
`default_nettype none
// ============================================================================
// Module   : spi2apb3_host_master
// Purpose  : APB3 register slave that acts as the frame master for an
//            SPI-to-APB3 bridge. Software programs OPCODE/ADDR/WDATA and sets
//            START. The block then shifts out one 112-bit frame on
//            SPICLK/SPIDI and captures a 32-bit read-back word from SPIDO.
//            SPICLK is derived from PCLK by a programmable divider.
// Ports    : PCLK, PRESETn        - clock, async active-low reset
//            PSEL..PWDATA         - APB3 slave request
//            PRDATA/PREADY/PSLVERR- APB3 slave response (no wait states)
//            SPICLK, SPIDI        - serial clock/data towards the bridge
//            SPIDO                - serial data from the bridge
//            IRQ                  - STATUS.DONE & CTRL.IE
// Revision : 1.0 - initial release
// ============================================================================
module spi2apb3_host_master #(
   parameter int DIV_RESET   = 4,
   parameter int IDLE_CYCLES = 8
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        SPICLK,
   output logic        SPIDI,
   input  logic        SPIDO,
   output logic        IRQ
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam logic [2:0]  REG_CTRL   = 3'd0;
   localparam logic [2:0]  REG_ADDR   = 3'd1;
   localparam logic [2:0]  REG_WDATA  = 3'd2;
   localparam logic [2:0]  REG_RDATA  = 3'd3;
   localparam logic [2:0]  REG_STATUS = 3'd4;
   localparam logic [2:0]  REG_CLKDIV = 3'd5;

   localparam logic [15:0] GAP_LAST   = 16'(IDLE_CYCLES - 1);
   localparam logic [6:0]  LAST_EDGE  = 7'd112;
   localparam logic [6:0]  RX_FIRST   = 7'd80;
   localparam logic [6:0]  RX_LAST    = 7'd111;

   logic [1:0]   state_q,  state_d;
   logic [15:0]  cnt_q,    cnt_d;
   logic [6:0]   bitcnt_q, bitcnt_d;
   logic [111:0] tx_q,     tx_d;
   logic [31:0]  rx_q,     rx_d;
   logic [7:0]   div_q,    div_d;
   logic [7:0]   opcode_q, opcode_d;
   logic         ie_q,     ie_d;
   logic [31:0]  addr_q,   addr_d;
   logic [31:0]  wdata_q,  wdata_d;
   logic [31:0]  rdata_q,  rdata_d;
   logic         done_q,   done_d;
   logic [7:0]   clkdiv_q, clkdiv_d;
   logic         spiclk_q, spiclk_d;
   logic         spidi_q,  spidi_d;

   logic         w_apb_wr;
   logic [2:0]   w_sel;
   logic         w_busy;
   logic         w_start;
   logic         w_phase_end;
   logic         w_gap_end;
   logic         w_unused;

   assign w_apb_wr    = PSEL & PENABLE & PWRITE;
   assign w_sel       = PADDR[4:2];
   // BUSY is taken from the registered state, so a START landing in the
   // same cycle the frame completes is still treated as busy.
   assign w_busy      = (state_q != ST_IDLE);
   assign w_start     = w_apb_wr & (w_sel == REG_CTRL) & PWDATA[8] & ~w_busy;
   assign w_phase_end = (cnt_q == {8'h00, div_q});
   assign w_gap_end   = (cnt_q == GAP_LAST);
   assign w_unused    = ^{PADDR[7:5], PADDR[1:0]};

   // ------------------------------------------------------------------
   // State register (and all other flops)
   // ------------------------------------------------------------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         div_q    <= '0;
         opcode_q <= '0;
         ie_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         done_q   <= 1'b0;
         clkdiv_q <= 8'(DIV_RESET);
         spiclk_q <= 1'b0;
         spidi_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         div_q    <= div_d;
         opcode_q <= opcode_d;
         ie_q     <= ie_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         done_q   <= done_d;
         clkdiv_q <= clkdiv_d;
         spiclk_q <= spiclk_d;
         spidi_q  <= spidi_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (w_start)     state_d = ST_LOW;
         ST_LOW:  if (w_phase_end) state_d = ST_HIGH;
         ST_HIGH: if (w_phase_end) state_d = (bitcnt_q == LAST_EDGE) ? ST_GAP : ST_LOW;
         ST_GAP:  if (w_gap_end)   state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath, register file and serial outputs
   // ------------------------------------------------------------------
   always_comb begin
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      div_d    = div_q;
      opcode_d = opcode_q;
      ie_d     = ie_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      done_d   = done_q;
      clkdiv_d = clkdiv_q;

      // Software-visible registers are frozen for the whole frame.
      if (w_apb_wr && !w_busy) begin
         case (w_sel)
            REG_CTRL: begin
               opcode_d = PWDATA[7:0];
               ie_d     = PWDATA[9];
            end
            REG_ADDR:   addr_d   = PWDATA;
            REG_WDATA:  wdata_d  = PWDATA;
            REG_CLKDIV: clkdiv_d = PWDATA[7:0];
            default: ;
         endcase
      end

      if (w_apb_wr && (w_sel == REG_STATUS) && PWDATA[1]) begin
         done_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (w_start) begin
               // Opcode comes from the same write that carries START.
               tx_d     = {PWDATA[7:0], 8'h00, addr_q, wdata_q, 32'h0};
               div_d    = clkdiv_q;
               bitcnt_d = '0;
               rx_d     = '0;
            end
         end
         ST_LOW: begin
            if (w_phase_end) begin
               cnt_d    = '0;
               bitcnt_d = bitcnt_q + 7'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_HIGH: begin
            if (w_phase_end) begin
               cnt_d = '0;
               // The bridge drives read data after rising edges 80..111.
               if ((bitcnt_q >= RX_FIRST) && (bitcnt_q <= RX_LAST)) begin
                  rx_d = {rx_q[30:0], SPIDO};
               end
               tx_d = {tx_q[110:0], 1'b0};
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_GAP: begin
            if (w_gap_end) begin
               cnt_d   = '0;
               rdata_d = rx_q;
               done_d  = 1'b1;   // completion beats a coincident W1C
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: cnt_d = '0;
      endcase

      // Serial pins are registered from the next state to stay glitch-free.
      spiclk_d = (state_d == ST_HIGH);
      spidi_d  = ((state_d == ST_LOW) || (state_d == ST_HIGH)) ? tx_d[111] : 1'b0;
   end

   // ------------------------------------------------------------------
   // APB read mux and fixed responses
   // ------------------------------------------------------------------
   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (w_sel)
            REG_CTRL:   PRDATA = {22'h0, ie_q, 1'b0, opcode_q};
            REG_ADDR:   PRDATA = addr_q;
            REG_WDATA:  PRDATA = wdata_q;
            REG_RDATA:  PRDATA = rdata_q;
            REG_STATUS: PRDATA = {30'h0, done_q, w_busy};
            REG_CLKDIV: PRDATA = {24'h0, clkdiv_q};
            default:    PRDATA = '0;
         endcase
      end
   end

   assign PREADY  = 1'b1;
   assign PSLVERR = 1'b0;
   assign SPICLK  = spiclk_q;
   assign SPIDI   = spidi_q;
   assign IRQ     = done_q & ie_q;

endmodule
`default_nettype wire

// File: tb/tb_spi2apb3_host_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi2apb3_host_master
// Purpose  : Directed self-checking bench for spi2apb3_host_master. Includes
//            a small bridge model that captures SPIDI on SPICLK rising edges
//            and returns a read word on SPIDO after edges 80..111.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi2apb3_host_master;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        PSEL, PENABLE, PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR, SPICLK, SPIDI, SPIDO, IRQ;

   int n_cmp = 0;
   int n_err = 0;

   // bridge / monitor state (written only by the monitor processes)
   int           edge_cnt;
   logic [111:0] cap;
   time          t_rise, t_fall, per_min, per_max, low_max;
   logic [31:0]  bridge_data;
   logic         clr;

   spi2apb3_host_master #(.DIV_RESET(4), .IDLE_CYCLES(8)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .SPICLK(SPICLK), .SPIDI(SPIDI),
      .SPIDO(SPIDO), .IRQ(IRQ)
   );

   always #5 PCLK = ~PCLK;

   always @(negedge SPICLK) t_fall = $time;

   always @(posedge SPICLK or posedge clr) begin
      if (clr) begin
         edge_cnt = 0;
         cap      = '0;
         per_min  = 64'hFFFF_FFFF_FFFF_FFFF;
         per_max  = 0;
         low_max  = 0;
         SPIDO    = 1'b0;
         t_rise   = 0;
      end else begin
         int e;
         if ((edge_cnt % 112) != 0) begin
            if ($time - t_rise < per_min) per_min = $time - t_rise;
            if ($time - t_rise > per_max) per_max = $time - t_rise;
         end else if (edge_cnt > 0) begin
            if ($time - t_fall > low_max) low_max = $time - t_fall;
         end
         t_rise   = $time;
         cap      = {cap[110:0], SPIDI};
         e        = (edge_cnt % 112) + 1;
         edge_cnt = edge_cnt + 1;
         #1;
         if (e >= 80 && e <= 111) SPIDO = bridge_data[111 - e];
         else                     SPIDO = 1'b0;
      end
   end

   // ---------------------------------------------------------------- APB
   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1 d = PRDATA;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic clear_mon();
      clr = 1'b1;
      #1 clr = 1'b0;
   endtask

   task automatic poll_done();
      logic [31:0] s;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         apb_read(8'h10, s);
         if (s[1]) begin ok = 1'b1; break; end
      end
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL poll_done: DONE got 0 required 1 (timeout)");
      end
   endtask

   task automatic wait_edges(input int n);
      for (int i = 0; i < 6000; i++) begin
         @(posedge PCLK); #1;
         if (edge_cnt >= n) break;
      end
      n_cmp++;
      if (edge_cnt < n) begin
         n_err++;
         $display("FAIL wait_edges: got %0d edges required %0d", edge_cnt, n);
      end
   endtask

   task automatic wait_fall();
      for (int i = 0; i < 300; i++) begin
         @(posedge PCLK); #1;
         if (!SPICLK) break;
      end
   endtask

   // -------------------------------------------------------------- tests
   task automatic test_reset();
      logic [7:0]  addrs [7];
      logic [31:0] exps  [7];
      logic [31:0] d;
      addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
      exps  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0};
      n_cmp++;
      if ({SPICLK, SPIDI, IRQ, PREADY, PSLVERR} !== 5'b00010) begin
         n_err++;
         $display("FAIL reset_pins: got %b required 00010", {SPICLK, SPIDI, IRQ, PREADY, PSLVERR});
      end
      for (int i = 0; i < 7; i++) begin
         apb_read(addrs[i], d);
         n_cmp++;
         if (d !== exps[i]) begin
            n_err++;
            $display("FAIL reset_reg %h: got %h required %h", addrs[i], d, exps[i]);
         end
      end
   endtask

   task automatic test_write_frame();
      logic [31:0]  d;
      logic [111:0] exp_frame;
      exp_frame = {8'hA0, 8'h00, 32'h2000_0010, 32'hDEAD_BEEF, 32'h0};
      clear_mon();
      bridge_data = 32'h0;
      apb_write(8'h14, 32'h1);
      apb_write(8'h04, 32'h2000_0010);
      apb_write(8'h08, 32'hDEAD_BEEF);
      apb_write(8'h00, 32'h0000_03A0);   // IE | START | opcode A0
      wait_edges(112);
      wait_fall();
      repeat (7) @(posedge PCLK);
      #1;
      n_cmp++;
      if (IRQ !== 1'b0) begin
         n_err++;
         $display("FAIL wr_done_early: IRQ got %b required 0 at gap cycle 7", IRQ);
      end
      @(posedge PCLK); #1;
      n_cmp++;
      if (IRQ !== 1'b1) begin
         n_err++;
         $display("FAIL wr_done_time: IRQ got %b required 1 at gap cycle 8", IRQ);
      end
      n_cmp++;
      if (edge_cnt !== 112) begin
         n_err++;
         $display("FAIL wr_edges: got %0d required 112", edge_cnt);
      end
      n_cmp++;
      if (per_min !== 40 || per_max !== 40) begin
         n_err++;
         $display("FAIL wr_period: got %0t..%0t required 40", per_min, per_max);
      end
      n_cmp++;
      if (cap !== exp_frame) begin
         n_err++;
         $display("FAIL wr_bits: got %h required %h", cap, exp_frame);
      end
      apb_read(8'h0C, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL wr_rdata: got %h required 00000000", d);
      end
      apb_read(8'h10, d);
      n_cmp++;
      if (d !== 32'h2) begin
         n_err++;
         $display("FAIL wr_status: got %h required 00000002", d);
      end
      apb_write(8'h10, 32'h2);
   endtask

   task automatic test_read_frame();
      logic [31:0] d;
      clear_mon();
      bridge_data = 32'h1234_5678;
      apb_write(8'h04, 32'h2000_0020);
      apb_write(8'h00, 32'h0000_0320);   // IE | START | opcode 20
      poll_done();
      apb_read(8'h0C, d);
      n_cmp++;
      if (d !== 32'h1234_5678) begin
         n_err++;
         $display("FAIL rd_rdata: got %h required 12345678", d);
      end
      n_cmp++;
      if (IRQ !== 1'b1) begin
         n_err++;
         $display("FAIL rd_irq: got %b required 1", IRQ);
      end
      n_cmp++;
      if (cap[111:104] !== 8'h20 || cap[95:64] !== 32'h2000_0020) begin
         n_err++;
         $display("FAIL rd_bits: got %h required opcode 20 addr 20000020", cap);
      end
      apb_write(8'h10, 32'h2);
      #1;
      n_cmp++;
      if (IRQ !== 1'b0) begin
         n_err++;
         $display("FAIL rd_irq_clr: got %b required 0", IRQ);
      end
   endtask

   task automatic test_busy_protect();
      logic [31:0] d;
      clear_mon();
      bridge_data = 32'h0;
      apb_write(8'h04, 32'h1111_2222);
      apb_write(8'h00, 32'h0000_01A0);   // START, IE=0
      wait_edges(20);
      apb_write(8'h00, 32'h0000_03FF);
      apb_write(8'h04, 32'hFFFF_FFFF);
      apb_write(8'h14, 32'h0);
      wait_edges(112);
      wait_fall();
      repeat (6) @(posedge PCLK);
      apb_write(8'h10, 32'h2);           // access edge coincides with DONE set
      apb_read(8'h10, d);
      n_cmp++;
      if (d !== 32'h2) begin
         n_err++;
         $display("FAIL busy_w1c_race: STATUS got %h required 00000002", d);
      end
      apb_read(8'h04, d);
      n_cmp++;
      if (d !== 32'h1111_2222) begin
         n_err++;
         $display("FAIL busy_addr: got %h required 11112222", d);
      end
      apb_read(8'h14, d);
      n_cmp++;
      if (d !== 32'h1) begin
         n_err++;
         $display("FAIL busy_clkdiv: got %h required 00000001", d);
      end
      apb_read(8'h00, d);
      n_cmp++;
      if (d !== 32'h0000_00A0) begin
         n_err++;
         $display("FAIL busy_ctrl: got %h required 000000A0", d);
      end
      n_cmp++;
      if (per_min !== 40 || per_max !== 40 || cap[95:64] !== 32'h1111_2222) begin
         n_err++;
         $display("FAIL busy_timing: period %0t..%0t addr bits %h required 40/11112222", per_min, per_max, cap[95:64]);
      end
      repeat (300) @(posedge PCLK);
      n_cmp++;
      if (edge_cnt !== 112) begin
         n_err++;
         $display("FAIL busy_no_second: got %0d edges required 112", edge_cnt);
      end
      apb_write(8'h10, 32'h2);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      clear_mon();
      bridge_data = 32'hCAFE_F00D;
      apb_write(8'h14, 32'h0);
      apb_write(8'h00, 32'h0000_0120);
      poll_done();
      apb_write(8'h10, 32'h2);
      apb_write(8'h00, 32'h0000_0120);
      poll_done();
      n_cmp++;
      if (edge_cnt !== 224) begin
         n_err++;
         $display("FAIL b2b_edges: got %0d required 224", edge_cnt);
      end
      n_cmp++;
      if (per_min !== 20 || per_max !== 20) begin
         n_err++;
         $display("FAIL b2b_period: got %0t..%0t required 20", per_min, per_max);
      end
      n_cmp++;
      if (low_max < 80) begin
         n_err++;
         $display("FAIL b2b_gap: got %0t required >= 80", low_max);
      end
      apb_read(8'h0C, d);
      n_cmp++;
      if (d !== 32'hCAFE_F00D) begin
         n_err++;
         $display("FAIL b2b_rdata: got %h required CAFEF00D", d);
      end
      apb_write(8'h10, 32'h2);
   endtask

   task automatic test_mid_reset();
      logic [31:0]  d;
      logic [111:0] exp_frame;
      exp_frame = {8'hC5, 8'h00, 32'h0BAD_F00D, 32'h5A5A_A5A5, 32'h0};
      clear_mon();
      apb_write(8'h14, 32'h1);
      apb_write(8'h00, 32'h0000_01A0);
      wait_edges(50);
      PRESETn = 1'b0;
      #1;
      n_cmp++;
      if (SPICLK !== 1'b0 || SPIDI !== 1'b0) begin
         n_err++;
         $display("FAIL rst_pins: SPICLK/SPIDI got %b%b required 00", SPICLK, SPIDI);
      end
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
      apb_read(8'h10, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL rst_status: got %h required 00000000", d);
      end
      apb_read(8'h0C, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL rst_rdata: got %h required 00000000", d);
      end
      clear_mon();
      bridge_data = 32'h0;
      apb_write(8'h04, 32'h0BAD_F00D);
      apb_write(8'h08, 32'h5A5A_A5A5);
      apb_write(8'h00, 32'h0000_01C5);
      poll_done();
      n_cmp++;
      if (edge_cnt !== 112 || cap !== exp_frame) begin
         n_err++;
         $display("FAIL rst_new_frame: edges %0d bits %h required 112 / %h", edge_cnt, cap, exp_frame);
      end
      n_cmp++;
      if (per_min !== 100 || per_max !== 100) begin
         n_err++;
         $display("FAIL rst_period: got %0t..%0t required 100", per_min, per_max);
      end
   endtask

   initial begin
      PRESETn = 1'b0;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0;
      bridge_data = '0;
      clr = 1'b0;
      #1 clr = 1'b1;
      #1 clr = 1'b0;
      repeat (4) @(posedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
      test_reset();
      test_write_frame();
      test_read_frame();
      test_busy_protect();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
